// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter between an instruction cache and
//               a data cache. Grants one requester at a time and drives the
//               shared RAM port. The dcache has default priority. An optional
//               anti-starvation streak counter guarantees icache progress.
//
// Build option: MEM_ARB_ANTISTARVE_EN
//               When defined, the streak counter and the forced-I rule are
//               compiled in. When undefined, the dcache has strict priority
//               and DSTREAK only takes part in the range check.
//
// Parameters  : DSTREAK  - maximum consecutive dcache completions while an
//                          icache request waits (1..15)
//
// Ports       : CLK       in   clock, rising edge
//               nRST      in   asynchronous active-low reset
//               iREN      in   icache read request
//               iaddr     in   icache word address
//               iwait     out  low for the single cycle an icache word returns
//               iload     out  instruction word, valid while iwait=0
//               dREN      in   dcache read request
//               dWEN      in   dcache write request (wins over dREN)
//               daddr     in   dcache word address
//               dstore    in   dcache write data
//               dwait     out  low for the single cycle a dcache access ends
//               dload     out  data word, valid while dwait=0 on a read
//               ramREN    out  RAM read strobe
//               ramWEN    out  RAM write strobe
//               ramaddr   out  RAM address
//               ramstore  out  RAM write data
//               ramload   in   RAM read data
//               ramstate  in   0=FREE 1=BUSY 2=ACCESS 3=ERROR
//
// Revision    : 1.0 - initial release
// ============================================================================

module mem_arbiter #(
    parameter int DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] c_RAM_ACCESS = 2'd2;

    // Elaboration-time guard on the streak limit; the counter is 4 bits wide.
    if ((DSTREAK < 1) || (DSTREAK > 15)) begin : g_dstreak_range_err
        $error("mem_arbiter: DSTREAK must lie in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic d_req;        // dcache wants the port (read or write)
    logic ram_access;   // RAM completes the access this cycle
    logic forced_i;     // icache must win the next arbitration
    logic ic_done;      // icache access completes this cycle
    logic dc_done;      // dcache access completes this cycle

    assign d_req      = dREN | dWEN;
    assign ram_access = (ramstate == c_RAM_ACCESS);

    // ------------------------------------------------------------------------
    // Next-state and output decode.
    // The port outputs depend on the registered grant state plus the live
    // request/RAM inputs: a wait must drop in the very cycle RAM reports
    // ACCESS, and strobes must drop in the same cycle a requester withdraws.
    // Because state_q resets asynchronously, every output returns to its
    // reset value as soon as nRST falls.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ic_done  = 1'b0;
        dc_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !forced_i) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end

            DGNT: begin
                if (!d_req) begin
                    // Requester withdrew before completion: abandon quietly.
                    state_d = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    // BUSY and ERROR simply hold the strobes and retry.
                    if (ram_access) begin
                        dwait   = 1'b0;
                        dc_done = 1'b1;
                        if (!dWEN) begin
                            dload = ramload;
                        end
                        state_d = IDLE;
                    end
                end
            end

            IGNT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ram_access) begin
                        iwait   = 1'b0;
                        iload   = ramload;
                        ic_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_ARB_ANTISTARVE_EN
    // ------------------------------------------------------------------------
    // Anti-starvation streak: counts dcache completions that happen while the
    // icache is waiting. Once it reaches DSTREAK the next arbitration goes to
    // the icache regardless of a pending dcache request.
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_STREAK_MAX = 4'(DSTREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;

    always_comb begin
        streak_d = streak_q;
        if (dc_done && iREN) begin
            if (streak_q != c_STREAK_MAX) begin
                streak_d = streak_q + 4'd1;
            end
        end else if (ic_done) begin
            streak_d = '0;
        end else if ((state_q == IDLE) && !iREN) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign forced_i = (streak_q == c_STREAK_MAX) && iREN;
`else
    // Strict dcache priority: the icache is never forced ahead.
    assign forced_i = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Each scenario
//               task drives the request and RAM-state inputs cycle by cycle
//               and compares outputs against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int tests;
    int fails;

    mem_arbiter #(
        .DSTREAK (4)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled a couple of ns later, well away from either edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = 2'd0;
    endtask

    // {iwait, dwait, ramREN, ramWEN}
    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        tick();
        tick();
        #2;
        tests++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, expected %b", {iwait, dwait, ramREN, ramWEN}, 4'b1100);
        end
        tests++;
        if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin
            fails++;
            $display("FAIL reset_data: got %h, expected 0", {iload, dload, ramaddr, ramstore});
        end
        nRST = 1'b1;

        // Start a write, then reset while it is granted and waiting on BUSY.
        tick();
        dWEN = 1'b1; daddr = 32'h0000_0500; dstore = 32'h0000_CAFE; ramstate = 2'd1;
        tick();
        #2;
        tests++;
        if ({ramWEN, ramaddr} !== {1'b1, 32'h0000_0500}) begin
            fails++;
            $display("FAIL reset_pre_dgnt: got %h, expected %h", {ramWEN, ramaddr}, {1'b1, 32'h0000_0500});
        end
        nRST = 1'b0;
        #1;
        tests++;
        if ({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore} !== {4'b1100, 64'd0}) begin
            fails++;
            $display("FAIL reset_async: got %h, expected %h", {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore}, {4'b1100, 64'd0});
        end
        clear_inputs();
        tick();
        #1;
        nRST = 1'b1;

        // After release the FSM must be in IDLE: a new fetch is granted one cycle later.
        tick();
        iREN = 1'b1; iaddr = 32'h0000_0600;
        #2;
        tests++;
        if (ramREN !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_after: got %b, expected 0", ramREN);
        end
        tick();
        #2;
        tests++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h0000_0600}) begin
            fails++;
            $display("FAIL reset_ignt_after: got %h, expected %h", {ramREN, ramaddr}, {1'b1, 32'h0000_0600});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_single_fetch();
        tick();
        iREN = 1'b1; iaddr = 32'h0000_0040;
        #2;
        tests++;
        if ({ramREN, iwait} !== 2'b01) begin
            fails++;
            $display("FAIL fetch_idle: got %b, expected 01", {ramREN, iwait});
        end
        tick();
        #2;
        tests++;
        if ({ramREN, ramWEN, ramaddr, iwait, iload} !== {2'b10, 32'h0000_0040, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL fetch_strobe: got %h, expected %h", {ramREN, ramWEN, ramaddr, iwait, iload}, {2'b10, 32'h0000_0040, 1'b1, 32'd0});
        end
        tick();
        ramstate = 2'd2; ramload = 32'h2408_0001;
        #2;
        tests++;
        if ({iwait, iload, dwait} !== {1'b0, 32'h2408_0001, 1'b1}) begin
            fails++;
            $display("FAIL fetch_done: got %h, expected %h", {iwait, iload, dwait}, {1'b0, 32'h2408_0001, 1'b1});
        end
        tick();
        ramstate = 2'd0;
        #2;
        tests++;
        if ({ramREN, iwait, iload, ramaddr} !== {2'b01, 64'd0}) begin
            fails++;
            $display("FAIL fetch_idle_after: got %h, expected %h", {ramREN, iwait, iload, ramaddr}, {2'b01, 64'd0});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_collision();
        tick();
        iREN = 1'b1; iaddr = 32'h0000_0200;
        dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        tick();
        ramstate = 2'd2;
        #2;
        tests++;
        if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h0000_0100, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL coll_dgnt: got %h, expected %h", {ramWEN, ramREN, ramaddr, ramstore}, {2'b10, 32'h0000_0100, 32'hDEAD_BEEF});
        end
        tests++;
        if ({dwait, iwait, iload} !== {2'b01, 32'd0}) begin
            fails++;
            $display("FAIL coll_dwait: got %h, expected %h", {dwait, iwait, iload}, {2'b01, 32'd0});
        end
        dWEN = 1'b0;
        tick();
        ramstate = 2'd0;
        #2;
        tests++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            fails++;
            $display("FAIL coll_idle: got %b, expected 0011", {ramREN, ramWEN, iwait, dwait});
        end
        tick();
        ramstate = 2'd2; ramload = 32'h1111_2222;
        #2;
        tests++;
        if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h0000_0200, 1'b0, 32'h1111_2222}) begin
            fails++;
            $display("FAIL coll_ignt: got %h, expected %h", {ramREN, ramaddr, iwait, iload}, {1'b1, 32'h0000_0200, 1'b0, 32'h1111_2222});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_withdrawal();
        tick();
        dREN = 1'b1; daddr = 32'h0000_0300; ramstate = 2'd1;
        tick();
        #2;
        tests++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h0000_0300}) begin
            fails++;
            $display("FAIL wd_grant: got %h, expected %h", {ramREN, ramaddr}, {1'b1, 32'h0000_0300});
        end
        dREN = 1'b0;
        #1;
        tests++;
        if ({ramREN, dwait, ramaddr} !== {2'b01, 32'd0}) begin
            fails++;
            $display("FAIL wd_drop: got %h, expected %h", {ramREN, dwait, ramaddr}, {2'b01, 32'd0});
        end
        // Back in IDLE: an icache request is seen now and granted next cycle.
        tick();
        iREN = 1'b1; iaddr = 32'h0000_0340; ramstate = 2'd0;
        #2;
        tests++;
        if ({ramREN, dwait} !== 2'b01) begin
            fails++;
            $display("FAIL wd_idle: got %b, expected 01", {ramREN, dwait});
        end
        tick();
        #2;
        tests++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h0000_0340}) begin
            fails++;
            $display("FAIL wd_next_grant: got %h, expected %h", {ramREN, ramaddr}, {1'b1, 32'h0000_0340});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_error_busy();
        tick();
        dREN = 1'b1; daddr = 32'h0000_0400; ramstate = 2'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            #2;
            tests++;
            if ({dwait, ramREN, ramaddr, dload} !== {2'b11, 32'h0000_0400, 32'd0}) begin
                fails++;
                $display("FAIL err_hold[%0d]: got %h, expected %h", c, {dwait, ramREN, ramaddr, dload}, {2'b11, 32'h0000_0400, 32'd0});
            end
        end
        tick();
        ramstate = 2'd2; ramload = 32'h1234_5678;
        #2;
        tests++;
        if ({dwait, dload, iwait} !== {1'b0, 32'h1234_5678, 1'b1}) begin
            fails++;
            $display("FAIL err_done: got %h, expected %h", {dwait, dload, iwait}, {1'b0, 32'h1234_5678, 1'b1});
        end
        tick();
        ramstate = 2'd0;
        #2;
        tests++;
        if ({ramREN, dwait, dload} !== {2'b01, 32'd0}) begin
            fails++;
            $display("FAIL err_idle: got %h, expected %h", {ramREN, dwait, dload}, {2'b01, 32'd0});
        end
        clear_inputs();
        tick();
    endtask

    // Both caches request continuously and RAM always answers at once, so a
    // completion lands every second cycle. evt bit k is set when the k-th
    // completion belongs to the icache.
    task automatic test_antistarve();
        logic [9:0] evt;
        logic [9:0] evt_exp;
        int         pulses;
        int         k;
        evt    = '0;
        pulses = 0;
        k      = 0;
`ifdef MEM_ARB_ANTISTARVE_EN
        evt_exp = 10'h210;
`else
        evt_exp = 10'h000;
`endif
        tick();
        iREN = 1'b1; iaddr = 32'h0000_0800;
        dREN = 1'b1; daddr = 32'h0000_0900;
        ramstate = 2'd2; ramload = 32'h0BAD_F00D;
        for (int c = 1; c < 20; c++) begin
            tick();
            #2;
            if (dwait == 1'b0) begin
                pulses++;
                k++;
            end
            if (iwait == 1'b0) begin
                if (k < 10) evt[k] = 1'b1;
                pulses++;
                k++;
            end
        end
        tests++;
        if (pulses !== 10) begin
            fails++;
            $display("FAIL starve_pulses: got %0d, expected 10", pulses);
        end
        tests++;
        if (evt !== evt_exp) begin
            fails++;
            $display("FAIL starve_order: got %b, expected %b", evt, evt_exp);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        nRST = 1'b0;
        test_reset();
        test_single_fetch();
        test_collision();
        test_withdrawal();
        test_error_busy();
        test_antistarve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
